addsub_nibble_seq: RTL and testbench

- Multi-cycle controller that computes WIDTH-bit add/subtract by time-sharing one 4-bit ripple-carry add/sub slice, one nibble per cycle, LSB nibble first.
- Carry/borrow chains between nibbles through a carry register.
- Valid/ready request and result handshakes.
- Sits between register-file style requesters and the 4-bit addsub datapath so wide arithmetic needs no wide adder.

---
 rtl/addsub_nibble_seq.sv | 135 +++++++++++++
 tb/tb_addsub_nibble_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_nibble_seq.sv
// addsub_nibble_seq: WIDTH-bit add/subtract built from one 4-bit slice,
// one nibble per cycle, LSB nibble first, with the carry kept in a register.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; req_a, req_b, req_sign (1 = A-B)
//   busy                  high while an operation is in RUN or DONE
//   res_valid/res_ready   result handshake; res_sum, res_cout (carry/borrow)
//   res_ovf               signed overflow, only when ADDSUB_SEQ_OVF_EN is defined
module addsub_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_sign,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
`ifdef ADDSUB_SEQ_OVF_EN
    output logic             res_cout,
    output logic             res_ovf
`else
    output logic             res_cout
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_sign;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             w_fire;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_slice;

    assign w_fire  = req_valid & req_ready;
    assign w_last  = (r_cnt == LAST);
    assign w_a_nib = r_a[{r_cnt, 2'b00} +: 4];
    // Subtraction inverts B here; the +1 comes from the preloaded carry.
    assign w_b_nib = r_b[{r_cnt, 2'b00} +: 4] ^ {4{r_sign}};
    assign w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  if (w_fire) w_state_nx = S_RUN;
            S_RUN:   if (w_last) w_state_nx = S_DONE;
            S_DONE:  if (res_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sign  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_sign  <= req_sign;
                        r_carry <= req_sign;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[{r_cnt, 2'b00} +: 4] <= w_slice[3:0];
                    r_carry <= w_slice[4];
                    // Counter parks at the last nibble instead of wrapping.
                    if (!w_last) r_cnt <= r_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign res_sum   = r_sum;
    // For subtraction the raw carry is "no borrow"; flip it into a borrow.
    assign res_cout  = res_valid & (r_carry ^ r_sign);

`ifdef ADDSUB_SEQ_OVF_EN
    logic r_bsgn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bsgn <= 1'b0;
        end else if (r_state == S_RUN && w_last) begin
            r_bsgn <= w_b_nib[3];
        end
    end

    assign res_ovf = res_valid
                   & (r_a[WIDTH-1] == r_bsgn)
                   & (r_sum[WIDTH-1] != r_a[WIDTH-1]);
`endif

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// tb_addsub_nibble_seq: directed bench for addsub_nibble_seq, WIDTH=16.
// Defines ADDSUB_SEQ_OVF_EN-aware checks of res_ovf.
module tb_addsub_nibble_seq;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_sign;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
`ifdef ADDSUB_SEQ_OVF_EN
    logic         res_ovf;
`endif

    int npass = 0;
    int ntot  = 0;

    addsub_nibble_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sign  (req_sign),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
`ifdef ADDSUB_SEQ_OVF_EN
        .res_cout  (res_cout),
        .res_ovf   (res_ovf)
`else
        .res_cout  (res_cout)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntot = ntot + 1;
        assert (got === exp) npass = npass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Wait for res_valid after an accept, counting cycles and busy cycles.
    task automatic wait_res(input string tag, output int lat,
                            output int nbusy);
        lat   = 0;
        nbusy = 1;
        while (!res_valid && lat < 20) begin
            chk({tag, "_rdy_low"}, {31'b0, req_ready}, 32'd0);
            tick();
            lat = lat + 1;
            if (busy) nbusy = nbusy + 1;
        end
        chk({tag, "_lat"}, lat, NIB);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] esum, input logic ecout,
                          input logic eovf);
        int lat;
        int nbusy;
        chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
        req_a     = a;
        req_b     = b;
        req_sign  = s;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        wait_res(tag, lat, nbusy);
        chk({tag, "_sum"}, {16'b0, res_sum}, {16'b0, esum});
        chk({tag, "_cout"}, {31'b0, res_cout}, {31'b0, ecout});
`ifdef ADDSUB_SEQ_OVF_EN
        chk({tag, "_ovf"}, {31'b0, res_ovf}, {31'b0, eovf});
`else
        if (eovf) begin
        end
`endif
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_nbusy"}, nbusy, NIB + 1);
        chk({tag, "_vdrop"}, {31'b0, res_valid}, 32'd0);
        chk({tag, "_idle"}, {30'b0, busy, req_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int nbusy;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_sign  = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_rdy", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_sum", {16'b0, res_sum}, 32'd0);
        chk("rst_cout", {31'b0, res_cout}, 32'd0);
`ifdef ADDSUB_SEQ_OVF_EN
        chk("rst_ovf", {31'b0, res_ovf}, 32'd0);
`endif
        tick();

        run_op("add1", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("add2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub1", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        run_op("sub2", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b0, 1'b0);
        run_op("ovf1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("ovf2", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        run_op("ovf3", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
        run_op("sub3", 16'hA5A5, 16'h5A5A, 1'b1, 16'h4B4B, 1'b0, 1'b1);

        // Backpressure, with a second request held from the cycle after accept.
        req_a     = 16'h00F0;
        req_b     = 16'h0F10;
        req_sign  = 1'b0;
        req_valid = 1'b1;
        tick();
        req_a    = 16'h0002;
        req_b    = 16'h0003;
        req_sign = 1'b0;
        wait_res("bp", lat, nbusy);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'b0, res_valid}, 32'd1);
            chk("bp_sum", {16'b0, res_sum}, 32'h1000);
            chk("bp_rdy", {31'b0, req_ready}, 32'd0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_rdy_after", {31'b0, req_ready}, 32'd1);
        chk("bp_busy_after", {31'b0, busy}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("bp2_busy", {31'b0, busy}, 32'd1);
        wait_res("bp2", lat, nbusy);
        chk("bp2_sum", {16'b0, res_sum}, 32'h0005);
        chk("bp2_cout", {31'b0, res_cout}, 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset after two nibble passes aborts the operation.
        req_a     = 16'hFFFF;
        req_b     = 16'h0001;
        req_sign  = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("ab_mid_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ab_busy", {31'b0, busy}, 32'd0);
        chk("ab_valid", {31'b0, res_valid}, 32'd0);
        chk("ab_sum", {16'b0, res_sum}, 32'd0);
        chk("ab_rdy", {31'b0, req_ready}, 32'd1);
        chk("ab_cout", {31'b0, res_cout}, 32'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ab_no_stale", {31'b0, res_valid}, 32'd0);
        end
        res_ready = 1'b0;

        run_op("post", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
